// File: rtl/conv_pkg.sv
// Shared definitions for the convolution coprocessor host-side control.
//   CONV_ADDR_W : default X/Y/Z memory address width (depth 2^CONV_ADDR_W)
//   seq_state_t : job sequencer states
//   conv_err_t  : sticky error codes reported to the host
package conv_pkg;

    localparam int CONV_ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        LAUNCH   = 3'd2,
        RUN      = 3'd3,
        COMPLETE = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_SIZE    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } conv_err_t;

endpackage

// File: rtl/conv_job_sequencer_if.sv
// Handshake bundle between the job sequencer and the convolution core.
//   core_start  : start level to the core (sequencer -> core)
//   core_rst    : one-cycle abort reset, active high (sequencer -> core)
//   core_size_x : X length latched for the job (sequencer -> core)
//   core_size_y : Y length latched for the job (sequencer -> core)
//   core_busy   : core busy flag (core -> sequencer)
//   core_done   : one-cycle completion pulse (core -> sequencer)
// master = sequencer side, slave = core side.
interface conv_job_sequencer_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = CONV_ADDR_W
);
    logic              core_start;
    logic              core_rst;
    logic [ADDR_W-1:0] core_size_x;
    logic [ADDR_W-1:0] core_size_y;
    logic              core_busy;
    logic              core_done;

    modport master (
        output core_start, core_rst, core_size_x, core_size_y,
        input  core_busy, core_done
    );

    modport slave (
        input  core_start, core_rst, core_size_x, core_size_y,
        output core_busy, core_done
    );
endinterface

// File: rtl/conv_watchdog.sv
// Job watchdog: up-counter with synchronous clear, parallel load and enable.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the count (highest priority after reset)
//   load      : load load_val into the count
//   load_val  : value for load
//   en        : count up by one per cycle
//   tc        : high while enabled and the count sits at TIMEOUT_CYCLES-1
module conv_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Gated by en so a stale terminal count left over in IDLE is never seen.
    assign tc = en && (count == TC_VAL);

endmodule

// File: rtl/conv_job_sequencer.sv
// Host-side job controller for the 1D convolution coprocessor.
// Validates the requested operand sizes, drives the core start handshake,
// guards the run with a watchdog and reports sticky status plus interrupt.
//   clk, rst       : clock, synchronous active-high reset
//   host_start     : start request, honoured only in IDLE
//   cfg_size_x/y   : requested X/Y lengths (1..2^ADDR_W-1)
//   host_irq_en    : interrupt enable
//   host_irq_clr   : clears sticky done/error
//   core           : master side of the core handshake bundle
//   status_busy    : sequencer not in IDLE
//   status_done    : sticky job-complete flag
//   status_err     : sticky error code (conv_err_t)
//   irq            : host_irq_en & (status_done | |status_err)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for host_start; sizes latched on acceptance
// CHECK    | one cycle: validate latched sizes, clear watchdog
// LAUNCH   | core_start high, waiting for core_busy
// RUN      | core running, waiting for core_done or watchdog expiry
// COMPLETE | one cycle: set status_done
module conv_job_sequencer
    import conv_pkg::*;
#(
    parameter int ADDR_W         = CONV_ADDR_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_start,
    input  logic [ADDR_W-1:0]    cfg_size_x,
    input  logic [ADDR_W-1:0]    cfg_size_y,
    input  logic                 host_irq_en,
    input  logic                 host_irq_clr,
    conv_job_sequencer_if.master core,
    output logic                 status_busy,
    output logic                 status_done,
    output logic [1:0]           status_err,
    output logic                 irq
);
    // size_x + size_y - 1 <= 2^ADDR_W  <=>  size_x + size_y <= 2^ADDR_W + 1
    localparam logic [ADDR_W:0] SUM_LIMIT = (ADDR_W + 1)'((1 << ADDR_W) + 1);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] size_x_q, size_y_q;
    logic [ADDR_W:0]   size_sum;
    logic              size_bad;

    logic              wd_clr, wd_en, wd_tc;

    logic              start_q, abort_q, busy_q, done_q, irq_q;
    conv_err_t         err_q;

    logic              start_d, abort_d, busy_d, done_d, irq_d;
    conv_err_t         err_d;
    logic              timeout, set_err;

    assign size_sum = {1'b0, size_x_q} + {1'b0, size_y_q};
    assign size_bad = (size_x_q == '0) || (size_y_q == '0) || (size_sum > SUM_LIMIT);

    assign wd_clr = (state == CHECK);
    assign wd_en  = (state == LAUNCH) || (state == RUN);

    conv_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (wd_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (wd_en),
        .tc       (wd_tc)
    );

    // State and registered outputs. Outputs are computed from the next state
    // so that they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            size_x_q <= '0;
            size_y_q <= '0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
            irq_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && host_start) begin
                size_x_q <= cfg_size_x;
                size_y_q <= cfg_size_y;
            end
            start_q <= start_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (host_start) state_nxt = CHECK;
            CHECK:    state_nxt = size_bad ? IDLE : LAUNCH;
            LAUNCH: begin
                if (wd_tc) begin
                    state_nxt = IDLE;
                end else if (core.core_busy) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // done takes priority over a simultaneous watchdog expiry
                if (core.core_done) begin
                    state_nxt = COMPLETE;
                end else if (wd_tc) begin
                    state_nxt = IDLE;
                end
            end
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        timeout = wd_tc && ((state == LAUNCH) || ((state == RUN) && !core.core_done));
        set_err = ((state == CHECK) && size_bad) || timeout;

        // Set events beat a same-cycle clear; a new error replaces the old code.
        if (state == COMPLETE) begin
            done_d = 1'b1;
        end else if (host_irq_clr) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        if (set_err) begin
            err_d = timeout ? ERR_TIMEOUT : ERR_SIZE;
        end else if (host_irq_clr) begin
            err_d = ERR_NONE;
        end else begin
            err_d = err_q;
        end

        start_d = (state_nxt == LAUNCH);
        abort_d = timeout;
        busy_d  = (state_nxt != IDLE);
        irq_d   = host_irq_en && (done_d || (err_d != ERR_NONE));
    end

    assign core.core_start  = start_q;
    assign core.core_rst    = abort_q;
    assign core.core_size_x = size_x_q;
    assign core.core_size_y = size_y_q;

    assign status_busy = busy_q;
    assign status_done = done_q;
    assign status_err  = err_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_conv_job_sequencer.sv
module tb_conv_job_sequencer;
    import conv_pkg::*;

    localparam int AW     = 5;
    localparam int T_A    = 64;
    localparam int T_B    = 16;
    localparam int BUDGET = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_start_a, host_start_b;
    logic [AW-1:0] cfg_size_x, cfg_size_y;
    logic          host_irq_en, host_irq_clr;
    logic          busy_a, done_a, irq_a;
    logic          busy_b, done_b, irq_b;
    logic [1:0]    err_a, err_b;

    int n_checks = 0;
    int n_pass   = 0;

    // results of the most recent run_job
    int ob_start_cnt, ob_start_t, ob_rst_cnt, ob_rst_t, ob_done_t, ob_end_t;
    bit ob_size_ok;

    conv_job_sequencer_if #(.ADDR_W(AW)) if_a ();
    conv_job_sequencer_if #(.ADDR_W(AW)) if_b ();

    conv_job_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(T_A)) dut_a (
        .clk(clk), .rst(rst), .host_start(host_start_a),
        .cfg_size_x(cfg_size_x), .cfg_size_y(cfg_size_y),
        .host_irq_en(host_irq_en), .host_irq_clr(host_irq_clr),
        .core(if_a), .status_busy(busy_a), .status_done(done_a),
        .status_err(err_a), .irq(irq_a)
    );

    conv_job_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(T_B)) dut_b (
        .clk(clk), .rst(rst), .host_start(host_start_b),
        .cfg_size_x(cfg_size_x), .cfg_size_y(cfg_size_y),
        .host_irq_en(host_irq_en), .host_irq_clr(host_irq_clr),
        .core(if_b), .status_busy(busy_b), .status_done(done_b),
        .status_err(err_b), .irq(irq_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    task automatic pulse_clr();
        host_irq_clr = 1'b1;
        @(negedge clk);
        host_irq_clr = 1'b0;
    endtask

    // Drives one job from a negedge. t=0 is the cycle host_start is high.
    // The core model raises busy b cycles after it first sees core_start and
    // pulses done d cycles after that (negative = never). poke re-requests a
    // start with other sizes in the first RUN cycle; clr_c asserts
    // host_irq_clr during the COMPLETE cycle.
    task automatic run_job(input bit sel, input int x, input int y, input int b,
                           input int d, input bit poke, input bit clr_c);
        int t = 0;
        int m = -1;
        bit fin = 0;
        logic cs, cr, sb, sd;
        logic [AW-1:0] szx, szy;
        ob_start_cnt = 0; ob_start_t = -1; ob_rst_cnt = 0; ob_rst_t = -1;
        ob_done_t = -1; ob_end_t = -1; ob_size_ok = 1;
        cfg_size_x = AW'(x);
        cfg_size_y = AW'(y);
        if (sel) host_start_b = 1'b1; else host_start_a = 1'b1;
        while (!fin && t < BUDGET) begin
            @(negedge clk);
            t++;
            host_start_a = 1'b0; host_start_b = 1'b0; host_irq_clr = 1'b0;
            if_a.core_done = 1'b0; if_b.core_done = 1'b0;
            cs  = sel ? if_b.core_start  : if_a.core_start;
            cr  = sel ? if_b.core_rst    : if_a.core_rst;
            sb  = sel ? busy_b           : busy_a;
            sd  = sel ? done_b           : done_a;
            szx = sel ? if_b.core_size_x : if_a.core_size_x;
            szy = sel ? if_b.core_size_y : if_a.core_size_y;
            if (cs) begin ob_start_cnt++; if (ob_start_t < 0) ob_start_t = t; end
            if (cr) begin ob_rst_cnt++; if (ob_rst_t < 0) ob_rst_t = t; end
            if (sd && ob_done_t < 0) ob_done_t = t;
            if (sb && (szx !== AW'(x) || szy !== AW'(y))) ob_size_ok = 0;
            if (!sb) begin
                ob_end_t = t;
                fin = 1;
            end else begin
                if (ob_start_t >= 0 && b >= 0 && t == ob_start_t + b) begin
                    if (sel) if_b.core_busy = 1'b1; else if_a.core_busy = 1'b1;
                end
                if (ob_start_t >= 0 && b >= 0 && d >= 0 && t == ob_start_t + b + d) begin
                    if (sel) begin if_b.core_done = 1'b1; if_b.core_busy = 1'b0; end
                    else begin if_a.core_done = 1'b1; if_a.core_busy = 1'b0; end
                    m = t;
                end
                if (poke && ob_start_t >= 0 && b >= 0 && t == ob_start_t + b + 1) begin
                    cfg_size_x = ~cfg_size_x;
                    cfg_size_y = ~cfg_size_y;
                    if (sel) host_start_b = 1'b1; else host_start_a = 1'b1;
                end
                if (clr_c && m >= 0 && t == m + 1) host_irq_clr = 1'b1;
            end
        end
        if_a.core_busy = 1'b0; if_b.core_busy = 1'b0;
        if_a.core_done = 1'b0; if_b.core_done = 1'b0;
        host_start_a = 1'b0; host_start_b = 1'b0; host_irq_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] va, vb;
        rst = 1'b1;
        host_irq_en = 1'b1;
        repeat (3) @(negedge clk);
        va = {if_a.core_start, if_a.core_rst, if_a.core_size_x, if_a.core_size_y, busy_a, done_a, err_a, irq_a};
        vb = {if_b.core_start, if_b.core_rst, if_b.core_size_x, if_b.core_size_y, busy_b, done_b, err_b, irq_b};
        n_checks++; if (va !== 18'h0) $display("FAIL reset_outputs_a: got %h expected 0", va); else n_pass++;
        n_checks++; if (vb !== 18'h0) $display("FAIL reset_outputs_b: got %h expected 0", vb); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        host_irq_en = 1'b1;
        pulse_clr();
        run_job(0, 5, 3, 2, 40, 0, 0);
        n_checks++; if (ob_start_t !== 2) $display("FAIL normal_launch_cycle: got %0d expected 2", ob_start_t); else n_pass++;
        n_checks++; if (ob_start_cnt !== 3) $display("FAIL normal_start_high: got %0d expected 3", ob_start_cnt); else n_pass++;
        n_checks++; if (ob_size_ok !== 1'b1) $display("FAIL normal_size_held: got %0d expected 1", ob_size_ok); else n_pass++;
        n_checks++; if (ob_done_t !== 46) $display("FAIL normal_done_rise: got %0d expected 46", ob_done_t); else n_pass++;
        n_checks++; if (ob_end_t !== 46) $display("FAIL normal_busy_fall: got %0d expected 46", ob_end_t); else n_pass++;
        n_checks++; if (irq_a !== 1'b1) $display("FAIL normal_irq: got %0b expected 1", irq_a); else n_pass++;
        n_checks++; if (err_a !== 2'b00) $display("FAIL normal_err: got %0b expected 00", err_a); else n_pass++;
        n_checks++; if (ob_rst_cnt !== 0) $display("FAIL normal_no_abort: got %0d expected 0", ob_rst_cnt); else n_pass++;
    endtask

    task automatic test_bad_size();
        pulse_clr();
        run_job(0, 0, 7, 0, 5, 0, 0);
        n_checks++; if (ob_end_t !== 2) $display("FAIL bad_x0_latency: got %0d expected 2", ob_end_t); else n_pass++;
        n_checks++; if (err_a !== 2'b01) $display("FAIL bad_x0_err: got %0b expected 01", err_a); else n_pass++;
        n_checks++; if (ob_start_cnt !== 0) $display("FAIL bad_x0_start: got %0d expected 0", ob_start_cnt); else n_pass++;
        n_checks++; if (done_a !== 1'b0) $display("FAIL bad_x0_done: got %0b expected 0", done_a); else n_pass++;
        run_job(0, 20, 13, 1, 5, 0, 0);
        n_checks++; if (ob_start_cnt !== 2) $display("FAIL edge_20_13_start: got %0d expected 2", ob_start_cnt); else n_pass++;
        n_checks++; if (done_a !== 1'b1) $display("FAIL edge_20_13_done: got %0b expected 1", done_a); else n_pass++;
        n_checks++; if (err_a !== 2'b01) $display("FAIL edge_err_sticky: got %0b expected 01", err_a); else n_pass++;
        pulse_clr();
        run_job(0, 20, 14, 1, 5, 0, 0);
        n_checks++; if (err_a !== 2'b01) $display("FAIL edge_20_14_err: got %0b expected 01", err_a); else n_pass++;
        n_checks++; if (ob_start_cnt !== 0) $display("FAIL edge_20_14_start: got %0d expected 0", ob_start_cnt); else n_pass++;
    endtask

    task automatic test_timeout();
        pulse_clr();
        run_job(1, 5, 3, 2, -1, 0, 0);
        n_checks++; if (ob_rst_t !== 2 + T_B) $display("FAIL timeout_rst_cycle: got %0d expected %0d", ob_rst_t, 2 + T_B); else n_pass++;
        n_checks++; if (ob_rst_cnt !== 1) $display("FAIL timeout_rst_width: got %0d expected 1", ob_rst_cnt); else n_pass++;
        n_checks++; if (err_b !== 2'b10) $display("FAIL timeout_err: got %0b expected 10", err_b); else n_pass++;
        n_checks++; if (ob_end_t !== 2 + T_B) $display("FAIL timeout_idle: got %0d expected %0d", ob_end_t, 2 + T_B); else n_pass++;
        @(negedge clk);
        n_checks++; if (if_b.core_rst !== 1'b0) $display("FAIL timeout_rst_drop: got %0b expected 0", if_b.core_rst); else n_pass++;
        pulse_clr();
        run_job(1, 4, 4, -1, -1, 0, 0);
        n_checks++; if (ob_start_cnt !== T_B) $display("FAIL timeout_launch_start: got %0d expected %0d", ob_start_cnt, T_B); else n_pass++;
        n_checks++; if (ob_rst_t !== 2 + T_B) $display("FAIL timeout_launch_rst: got %0d expected %0d", ob_rst_t, 2 + T_B); else n_pass++;
    endtask

    task automatic test_done_on_timeout();
        pulse_clr();
        run_job(1, 0, 3, 0, 1, 0, 0);
        run_job(1, 6, 6, 2, T_B - 3, 0, 0);
        n_checks++; if (ob_rst_cnt !== 0) $display("FAIL done_tc_no_abort: got %0d expected 0", ob_rst_cnt); else n_pass++;
        n_checks++; if (done_b !== 1'b1) $display("FAIL done_tc_done: got %0b expected 1", done_b); else n_pass++;
        n_checks++; if (err_b !== 2'b01) $display("FAIL done_tc_err_kept: got %0b expected 01", err_b); else n_pass++;
        n_checks++; if (ob_end_t !== 2 + T_B - 1 + 2) $display("FAIL done_tc_idle: got %0d expected %0d", ob_end_t, 2 + T_B + 1); else n_pass++;
        run_job(1, 6, 6, 2, T_B - 2, 0, 0);
        n_checks++; if (ob_rst_t !== 2 + T_B) $display("FAIL done_late_abort: got %0d expected %0d", ob_rst_t, 2 + T_B); else n_pass++;
        n_checks++; if (err_b !== 2'b10) $display("FAIL done_late_err: got %0b expected 10", err_b); else n_pass++;
    endtask

    task automatic test_clr_vs_set();
        host_irq_en = 1'b1;
        pulse_clr();
        run_job(0, 3, 3, 1, 6, 0, 1);
        n_checks++; if (done_a !== 1'b1) $display("FAIL clr_vs_set_done: got %0b expected 1", done_a); else n_pass++;
        pulse_clr();
        n_checks++; if (done_a !== 1'b0) $display("FAIL clr_alone_done: got %0b expected 0", done_a); else n_pass++;
        n_checks++; if (irq_a !== 1'b0) $display("FAIL clr_alone_irq: got %0b expected 0", irq_a); else n_pass++;
    endtask

    task automatic test_ignore_start();
        pulse_clr();
        run_job(0, 9, 11, 1, 8, 1, 0);
        n_checks++; if (ob_size_ok !== 1'b1) $display("FAIL ignore_sizes_held: got %0d expected 1", ob_size_ok); else n_pass++;
        n_checks++; if (ob_start_cnt !== 2) $display("FAIL ignore_start_high: got %0d expected 2", ob_start_cnt); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b0) $display("FAIL ignore_no_new_job: got %0b expected 0", busy_a); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [17:0] va;
        host_irq_en = 1'b1;
        run_job(0, 0, 5, 0, 1, 0, 0);
        cfg_size_x = 5'd7;
        cfg_size_y = 5'd9;
        host_start_a = 1'b1;
        @(negedge clk);
        host_start_a = 1'b0;
        @(negedge clk);
        if_a.core_busy = 1'b1;
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b1) $display("FAIL midrst_running: got %0b expected 1", busy_a); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_a.core_busy = 1'b0;
        va = {if_a.core_start, if_a.core_rst, if_a.core_size_x, if_a.core_size_y, busy_a, done_a, err_a, irq_a};
        n_checks++; if (va !== 18'h0) $display("FAIL midrst_outputs: got %h expected 0", va); else n_pass++;
        @(negedge clk);
        n_checks++; if (if_a.core_rst !== 1'b0) $display("FAIL midrst_no_abort: got %0b expected 0", if_a.core_rst); else n_pass++;
        run_job(0, 7, 9, 2, 10, 0, 0);
        n_checks++; if (done_a !== 1'b1) $display("FAIL midrst_fresh_done: got %0b expected 1", done_a); else n_pass++;
        n_checks++; if (ob_end_t !== 16) $display("FAIL midrst_fresh_len: got %0d expected 16", ob_end_t); else n_pass++;
    endtask

    // Reference model: acceptance from the size rule, job length and flags
    // from the timing rules, sticky flags tracked across jobs.
    task automatic test_random();
        int x, y, b, d, e_start, e_end, e_rst;
        bit acc, en, m_done, e_irq;
        int m_err;
        pulse_clr();
        m_done = 0;
        m_err  = 0;
        for (int i = 0; i < 24; i++) begin
            x  = $urandom_range(0, 31);
            y  = $urandom_range(0, 31);
            b  = $urandom_range(0, 4);
            d  = $urandom_range(1, 70);
            en = 1'($urandom_range(0, 1));
            host_irq_en = en;
            acc = (x != 0) && (y != 0) && (x + y - 1 <= (1 << AW));
            e_rst = 0;
            if (!acc) begin
                e_start = 0; e_end = 2; m_err = 1;
            end else if (b + d > T_A - 1) begin
                e_start = b + 1; e_end = 2 + T_A; e_rst = 1; m_err = 2;
            end else begin
                e_start = b + 1; e_end = 2 + b + d + 2; m_done = 1;
            end
            e_irq = en && (m_done || m_err != 0);
            run_job(0, x, y, b, d, 0, 0);
            n_checks++; if (ob_start_cnt !== e_start) $display("FAIL rand%0d_start: got %0d expected %0d", i, ob_start_cnt, e_start); else n_pass++;
            n_checks++; if (ob_end_t !== e_end) $display("FAIL rand%0d_len: got %0d expected %0d", i, ob_end_t, e_end); else n_pass++;
            n_checks++; if (ob_rst_cnt !== e_rst) $display("FAIL rand%0d_abort: got %0d expected %0d", i, ob_rst_cnt, e_rst); else n_pass++;
            n_checks++; if (done_a !== m_done) $display("FAIL rand%0d_done: got %0b expected %0b", i, done_a, m_done); else n_pass++;
            n_checks++; if (err_a !== 2'(m_err)) $display("FAIL rand%0d_err: got %0d expected %0d", i, err_a, m_err); else n_pass++;
            n_checks++; if (irq_a !== e_irq) $display("FAIL rand%0d_irq: got %0b expected %0b", i, irq_a, e_irq); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        host_start_a = 1'b0;
        host_start_b = 1'b0;
        cfg_size_x = '0;
        cfg_size_y = '0;
        host_irq_en = 1'b1;
        host_irq_clr = 1'b0;
        if_a.core_busy = 1'b0; if_a.core_done = 1'b0;
        if_b.core_busy = 1'b0; if_b.core_done = 1'b0;
        test_reset();
        test_normal();
        test_bad_size();
        test_timeout();
        test_done_on_timeout();
        test_clr_vs_set();
        test_ignore_start();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
